oled_text_scheduler: RTL and testbench

// Shares OLEDCtrl's character-write and update ports among NUM_REQ text

---
 rtl/oled_text_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_oled_text_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_text_scheduler.sv
// Round-robin scheduler sharing OLEDCtrl's character-write and update ports among
// NUM_REQ row writers; each grant streams one 16-char row then optionally one update.
module oled_text_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CHARS       = 16,
    parameter int unsigned AUTO_UPDATE = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [2*NUM_REQ-1:0]         req_row,
    input  logic [8*CHARS*NUM_REQ-1:0]   req_line,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    input  logic                         upd_req,
    output logic                         busy,
    output logic                         write_start,
    output logic [8:0]                   write_base_addr,
    output logic [7:0]                   write_ascii_data,
    input  logic                         write_ready,
    output logic                         update_start,
    output logic                         update_clear,
    input  logic                         update_ready
);

    localparam int unsigned LINE_W = 8 * CHARS;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned ROW_W  = 2;

    typedef enum logic [2:0] {
        IDLE, WSETUP, WPULSE, WWAIT, USTART, UWAIT, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                first_q, first_d;
    logic [NUM_REQ-1:0]  gnt_d, done_d;
    logic                busy_d, write_start_d, update_start_d;
    logic [8:0]          addr_d;
    logic [7:0]          data_d;

    logic                found;
    logic [PTR_W-1:0]    pick;
    int unsigned         idx;

    // Round-robin pick: first asserted request at or after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        rr_d           = rr_q;
        win_d          = win_q;
        row_d          = row_q;
        line_d         = line_q;
        first_d        = 1'b0;
        gnt_d          = gnt;
        done_d         = '0;
        write_start_d  = 1'b0;
        update_start_d = 1'b0;
        addr_d         = write_base_addr;
        data_d         = write_ascii_data;

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    gnt_d   = NUM_REQ'(1) << pick;
                    row_d   = req_row[ROW_W*int'(pick) +: ROW_W];
                    line_d  = req_line[LINE_W*int'(pick) +: LINE_W];
                    col_d   = '0;
                    state_d = WSETUP;
                end else if (upd_req) begin
                    state_d = USTART;
                end
            end
            WSETUP: begin
                addr_d  = {row_q, col_q, 3'b000};
                data_d  = line_q[8*(CHARS-1-int'(col_q)) +: 8];
                state_d = WPULSE;
            end
            WPULSE: begin
                if (write_ready) begin
                    write_start_d = 1'b1;
                    first_d       = 1'b1;
                    state_d       = WWAIT;
                end
            end
            WWAIT: begin
                // OLEDCtrl only drops write_ready a cycle after seeing the pulse.
                if (!first_q && write_ready) begin
                    if (col_q == COL_W'(CHARS - 1)) begin
                        state_d = (AUTO_UPDATE != 0) ? USTART : FIN;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = WSETUP;
                    end
                end
            end
            USTART: begin
                if (update_ready) begin
                    update_start_d = 1'b1;
                    first_d        = 1'b1;
                    state_d        = UWAIT;
                end
            end
            UWAIT: begin
                if (!first_q && update_ready) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Standalone updates carry no grant and leave the pointer alone.
                if (|done) begin
                    rr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FIN && state_q != FIN) begin
            done_d = gnt;
            gnt_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            col_q            <= '0;
            rr_q             <= '0;
            win_q            <= '0;
            row_q            <= '0;
            line_q           <= '0;
            first_q          <= 1'b0;
            gnt              <= '0;
            done             <= '0;
            busy             <= 1'b0;
            write_start      <= 1'b0;
            update_start     <= 1'b0;
            write_base_addr  <= '0;
            write_ascii_data <= '0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            rr_q             <= rr_d;
            win_q            <= win_d;
            row_q            <= row_d;
            line_q           <= line_d;
            first_q          <= first_d;
            gnt              <= gnt_d;
            done             <= done_d;
            busy             <= busy_d;
            write_start      <= write_start_d;
            update_start     <= update_start_d;
            write_base_addr  <= addr_d;
            write_ascii_data <= data_d;
        end
    end

    assign update_clear = 1'b0;

endmodule

// File: tb/tb_oled_text_scheduler.sv
// Scoreboard bench for oled_text_scheduler: one auto-update instance, one manual-update
// instance, sharing a small OLEDCtrl ready/handshake model.
module tb_oled_text_scheduler;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic [N-1:0]     req_a = '0, req_b = '0;
    logic [2*N-1:0]   row_a = '0, row_b = '0;
    logic [128*N-1:0] line_a = '0, line_b = '0;
    logic             upd_a = 1'b0, upd_b = 1'b0;

    logic [N-1:0] gnt_a, done_a, gnt_b, done_b;
    logic         busy_a, ws_a, us_a, uc_a, busy_b, ws_b, us_b, uc_b;
    logic [8:0]   addr_a, addr_b;
    logic [7:0]   data_a, data_b;

    logic write_ready = 1'b1;
    logic update_ready = 1'b1;
    int   wcnt = 0, ucnt = 0, wlat = 2;

    int n_checks = 0;
    int n_fail = 0;
    int upd_seen_a = 0, upd_seen_b = 0;
    logic [16:0] wq[$];

    oled_text_scheduler #(.NUM_REQ(N), .CHARS(16), .AUTO_UPDATE(1)) dut_a (
        .clk(clk), .rstn(rstn), .req(req_a), .req_row(row_a), .req_line(line_a),
        .gnt(gnt_a), .done(done_a), .upd_req(upd_a), .busy(busy_a),
        .write_start(ws_a), .write_base_addr(addr_a), .write_ascii_data(data_a),
        .write_ready(write_ready), .update_start(us_a), .update_clear(uc_a),
        .update_ready(update_ready)
    );

    oled_text_scheduler #(.NUM_REQ(N), .CHARS(16), .AUTO_UPDATE(0)) dut_b (
        .clk(clk), .rstn(rstn), .req(req_b), .req_row(row_b), .req_line(line_b),
        .gnt(gnt_b), .done(done_b), .upd_req(upd_b), .busy(busy_b),
        .write_start(ws_b), .write_base_addr(addr_b), .write_ascii_data(data_b),
        .write_ready(write_ready), .update_start(us_b), .update_clear(uc_b),
        .update_ready(update_ready)
    );

    always #5 clk = ~clk;

    // OLEDCtrl stand-in: ready drops on the edge that samples a start, returns after a latency.
    always @(posedge clk) begin
        if (write_ready) begin
            if (ws_a || ws_b) begin
                write_ready <= 1'b0;
                wcnt        <= wlat;
            end
        end else if (wcnt == 0) begin
            write_ready <= 1'b1;
        end else begin
            wcnt <= wcnt - 1;
        end
        if (update_ready) begin
            if (us_a || us_b) begin
                update_ready <= 1'b0;
                ucnt         <= 3;
            end
        end else if (ucnt == 0) begin
            update_ready <= 1'b1;
        end else begin
            ucnt <= ucnt - 1;
        end
    end

    // Monitor: pops expected writes and checks handshake rules every cycle.
    initial begin
        logic [16:0] exp_w, got_w;
        forever begin
            @(negedge clk);
            if (ws_a || ws_b) begin
                n_checks++;
                if (!write_ready || (ws_a && ws_b)) begin
                    n_fail++;
                    $display("FAIL write_start_ready: ws_a=%0b ws_b=%0b write_ready=%0b, required one start with ready=1",
                             ws_a, ws_b, write_ready);
                end
                got_w = ws_a ? {addr_a, data_a} : {addr_b, data_b};
                n_checks++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: addr=%h data=%h, required no write", got_w[16:8], got_w[7:0]);
                end else begin
                    exp_w = wq.pop_front();
                    if (got_w !== exp_w) begin
                        n_fail++;
                        $display("FAIL write_payload: addr=%h data=%h, required addr=%h data=%h",
                                 got_w[16:8], got_w[7:0], exp_w[16:8], exp_w[7:0]);
                    end
                end
            end
            if (us_a || us_b) begin
                n_checks++;
                if (!update_ready) begin
                    n_fail++;
                    $display("FAIL update_start_ready: update_ready=%0b, required 1", update_ready);
                end
                if (us_a) upd_seen_a++;
                if (us_b) upd_seen_b++;
            end
            n_checks++;
            if (!$onehot0(gnt_a) || !$onehot0(gnt_b) || uc_a !== 1'b0 || uc_b !== 1'b0) begin
                n_fail++;
                $display("FAIL gnt_onehot_clear: gnt_a=%b gnt_b=%b uc_a=%b uc_b=%b, required one-hot/zero and clear=0",
                         gnt_a, gnt_b, uc_a, uc_b);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion within 40000 cycles");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] str2line(input string s);
        logic [127:0] l = '0;
        for (int c = 0; c < 16; c++) l = {l[119:0], 8'(s[c])};
        return l;
    endfunction

    task automatic push_row(input int row, input string s);
        for (int c = 0; c < 16; c++) wq.push_back({9'(row * 128 + c * 8), 8'(s[c])});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_gnt(input bit b, output logic [N-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            g = b ? gnt_b : gnt_a;
            if (g != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input bit b, output logic [N-1:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            d = b ? done_b : done_a;
            if (d != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt_a, done_a, busy_a, ws_a, us_a, uc_a, addr_a, data_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: gnt=%b done=%b busy=%b ws=%b us=%b addr=%h data=%h, required all 0",
                     gnt_a, done_a, busy_a, ws_a, us_a, addr_a, data_a);
        end
        n_checks++;
        if ({gnt_b, done_b, busy_b, ws_b, us_b, uc_b, addr_b, data_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: gnt=%b done=%b busy=%b ws=%b us=%b addr=%h data=%h, required all 0",
                     gnt_b, done_b, busy_b, ws_b, us_b, addr_b, data_b);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single_row();
        logic [N-1:0] g, d;
        bit ok;
        int u0;
        string s = "HELLO WORLD     ";
        do_reset();
        u0 = upd_seen_a;
        push_row(2, s);
        row_a[1:0]    = 2'd2;
        line_a[127:0] = str2line(s);
        req_a[0]      = 1'b1;
        wait_gnt(1'b0, g, ok);
        req_a[0] = 1'b0;
        n_checks++;
        if (!ok || g !== 4'b0001 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gnt: gnt=%b busy=%b, required gnt=0001 busy=1", g, busy_a);
        end
        wait_done(1'b0, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_done: done=%b, required 0001", d);
        end
        @(negedge clk);
        n_checks++;
        if (done_a !== '0) begin
            n_fail++;
            $display("FAIL single_done_pulse: done=%b one cycle later, required 0000", done_a);
        end
        n_checks++;
        if (upd_seen_a !== u0 + 1 || wq.size() !== 0) begin
            n_fail++;
            $display("FAIL single_counts: updates=%0d writes_left=%0d, required 1 and 0", upd_seen_a - u0, wq.size());
        end
        wq.delete();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, d;
        bit ok;
        int u0;
        do_reset();
        u0 = upd_seen_a;
        for (int i = 0; i < N; i++) begin
            logic [127:0] l;
            for (int c = 0; c < 16; c++) l[127-8*c -: 8] = 8'(32 + 16 * i + c);
            row_a[2*i +: 2]    = 2'(i);
            line_a[128*i +: 128] = l;
        end
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int i = k % 4;
            for (int c = 0; c < 16; c++) wq.push_back({9'(i * 128 + c * 8), 8'(32 + 16 * i + c)});
            wait_gnt(1'b0, g, ok);
            n_checks++;
            if (!ok || g !== 4'(1 << i)) begin
                n_fail++;
                $display("FAIL rr_gnt_%0d: gnt=%b, required %b", k, g, 4'(1 << i));
            end
            wait_done(1'b0, d, ok);
            if (k == 4) req_a = '0;
            n_checks++;
            if (!ok || d !== 4'(1 << i)) begin
                n_fail++;
                $display("FAIL rr_done_%0d: done=%b, required %b", k, d, 4'(1 << i));
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (upd_seen_a !== u0 + 5 || wq.size() !== 0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_counts: updates=%0d writes_left=%0d busy=%b, required 5, 0, 0",
                     upd_seen_a - u0, wq.size(), busy_a);
        end
        wq.delete();
    endtask

    task automatic test_write_stall();
        logic [N-1:0] g, d;
        bit ok;
        int starts;
        string s = "stall-test-line!";
        do_reset();
        push_row(3, s);
        row_a[3:2]      = 2'd3;
        line_a[255:128] = str2line(s);
        wlat     = 50;
        req_a[1] = 1'b1;
        wait_gnt(1'b0, g, ok);
        req_a[1] = 1'b0;
        n_checks++;
        if (!ok || g !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_gnt: gnt=%b, required 0010", g);
        end
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (ws_a) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 wlat = 2;
        starts = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (ws_a) starts++;
        end
        n_checks++;
        if (!ok || starts !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: first_write_seen=%b starts_during_stall=%0d, required 1 and 0", ok, starts);
        end
        wait_done(1'b0, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0010 || wq.size() !== 0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b writes_left=%0d, required 0010 and 0", d, wq.size());
        end
        wq.delete();
    endtask

    task automatic test_manual_update();
        logic [N-1:0] g, d, dor;
        bit ok;
        int u0;
        string s = "auto-update off!";
        do_reset();
        u0 = upd_seen_b;
        push_row(1, s);
        row_b[5:4]      = 2'd1;
        line_b[383:256] = str2line(s);
        req_b[2]        = 1'b1;
        wait_gnt(1'b1, g, ok);
        req_b[2] = 1'b0;
        n_checks++;
        if (!ok || g !== 4'b0100) begin
            n_fail++;
            $display("FAIL manual_gnt: gnt=%b, required 0100", g);
        end
        wait_done(1'b1, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0100 || upd_seen_b !== u0 || wq.size() !== 0) begin
            n_fail++;
            $display("FAIL manual_row: done=%b updates=%0d writes_left=%0d, required 0100, 0, 0",
                     d, upd_seen_b - u0, wq.size());
        end
        repeat (2) @(negedge clk);
        upd_b = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (busy_b) ok = 1'b1;
        end
        upd_b = 1'b0;
        dor = '0;
        for (int n = 0; n < 100 && busy_b; n++) begin
            dor |= done_b;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || busy_b !== 1'b0 || upd_seen_b !== u0 + 1 || dor !== '0 || gnt_b !== '0) begin
            n_fail++;
            $display("FAIL manual_update: started=%b busy=%b updates=%0d done_or=%b gnt=%b, required 1, 0, 1, 0000, 0000",
                     ok, busy_b, upd_seen_b - u0, dor, gnt_b);
        end
        wq.delete();
    endtask

    task automatic test_reset_midrow();
        logic [N-1:0] g, d;
        bit ok;
        string s1 = "first-rr-advance";
        string s3 = "abort-at-column7";
        string s2 = "after-reset-row1";
        do_reset();
        push_row(1, s1);
        row_a[3:2]      = 2'd1;
        line_a[255:128] = str2line(s1);
        req_a[1]        = 1'b1;
        wait_gnt(1'b0, g, ok);
        req_a[1] = 1'b0;
        wait_done(1'b0, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_pre_done: done=%b, required 0010", d);
        end
        push_row(0, s3);
        row_a[7:6]      = 2'd0;
        line_a[511:384] = str2line(s3);
        req_a[3]        = 1'b1;
        wait_gnt(1'b0, g, ok);
        req_a[3] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (ws_a && addr_a == 9'h038) ok = 1'b1;
        end
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (!ok || {gnt_a, done_a, busy_a, ws_a, us_a, uc_a, addr_a, data_a} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: reached_col7=%b gnt=%b busy=%b ws=%b addr=%h data=%h, required 1 and all 0",
                     ok, gnt_a, busy_a, ws_a, addr_a, data_a);
        end
        wq.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        push_row(1, s2);
        line_a[255:128] = str2line(s2);
        req_a = 4'b1010;
        wait_gnt(1'b0, g, ok);
        req_a = '0;
        n_checks++;
        if (!ok || g !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_rr_reset: gnt=%b, required 0010", g);
        end
        wait_done(1'b0, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0010 || wq.size() !== 0) begin
            n_fail++;
            $display("FAIL abort_restart: done=%b writes_left=%0d, required 0010 and 0", d, wq.size());
        end
        wq.delete();
    endtask

    task automatic test_line_latch();
        logic [N-1:0] g, d;
        bit ok;
        string s_old = "latched-at-grant";
        string s_new = "changed-too-late";
        do_reset();
        push_row(0, s_old);
        row_a[1:0]    = 2'd0;
        line_a[127:0] = str2line(s_old);
        req_a[0]      = 1'b1;
        wait_gnt(1'b0, g, ok);
        req_a[0]      = 1'b0;
        row_a[1:0]    = 2'd3;
        line_a[127:0] = str2line(s_new);
        n_checks++;
        if (!ok || g !== 4'b0001) begin
            n_fail++;
            $display("FAIL latch_gnt: gnt=%b, required 0001", g);
        end
        wait_done(1'b0, d, ok);
        n_checks++;
        if (!ok || d !== 4'b0001 || wq.size() !== 0) begin
            n_fail++;
            $display("FAIL latch_done: done=%b writes_left=%0d, required 0001 and 0", d, wq.size());
        end
        wq.delete();
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_round_robin();
        test_write_stall();
        test_manual_update();
        test_reset_midrow();
        test_line_latch();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
